// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: CPU MEM stage has combinational priority, debug port uses req/ack.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module data_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_dbg_cnt
);

  typedef enum logic {IDLE, DONE} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       grant_dbg;

  // Reset suppresses the grant so neither a debug write nor a stall can leak out during reset.
  assign grant_dbg = !rst && (state == IDLE) && dbg_req &&
                     (!cpu_req || (wait_cnt == STARVE_MAX));

  assign cpu_stall = grant_dbg && cpu_req;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we && cpu_req;
    if (grant_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end
    if (rst) mem_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state   <= grant_dbg ? DONE : IDLE;
      dbg_ack <= grant_dbg;
      if (grant_dbg) dbg_rdata <= mem_rdata;
      if (state == IDLE) begin
        if (grant_dbg || !dbg_req) wait_cnt <= '0;
        else if (cpu_req)          wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] dbg_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      if (cpu_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (grant_dbg && (dbg_cnt_q != 32'hFFFF_FFFF))   dbg_cnt_q   <= dbg_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_dbg_cnt   = dbg_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_dbg_cnt   = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256-word behavioural data memory.
module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [31:0]   perf_stall_cnt, perf_dbg_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_dbg_cnt(perf_dbg_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset: no write, no stall even with a CPU write and a debug request pending.
    settle();
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h33;
    settle();
    check("rst_dbg_mem_we", {31'b0, mem_we}, 32'd0);
    next_cycle();
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    settle();
    check("post_rst_ack", {31'b0, dbg_ack}, 32'd0);
    check("post_rst_rdata", dbg_rdata, 32'd0);
    check("post_rst_perf_stall", perf_stall_cnt, 32'd0);
    check("post_rst_perf_dbg", perf_dbg_cnt, 32'd0);

    // CPU passthrough write then read.
    cpu_write(8'h10, 32'hDEAD_BEEF);
    settle();
    check("cpu_wr_we", {31'b0, mem_we}, 32'd1);
    check("cpu_wr_addr", {24'b0, mem_addr}, 32'h10);
    check("cpu_wr_stall", {31'b0, cpu_stall}, 32'd0);
    next_cycle();
    cpu_we = 1'b0;
    settle();
    check("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
    check("cpu_rd_stall", {31'b0, cpu_stall}, 32'd0);
    cpu_write(8'h20, 32'h0000_1234);
    cpu_write(8'h50, 32'h5555_0050);

    // Idle debug read of 0x20.
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    settle();
    check("idle_grant_addr", {24'b0, mem_addr}, 32'h20);
    check("idle_grant_stall", {31'b0, cpu_stall}, 32'd0);
    check("idle_grant_ack", {31'b0, dbg_ack}, 32'd0);
    next_cycle();
    dbg_req = 1'b0;
    settle();
    check("idle_ack", {31'b0, dbg_ack}, 32'd1);
    check("idle_rdata", dbg_rdata, 32'h0000_1234);
    next_cycle();
    settle();
    check("idle_ack_pulse", {31'b0, dbg_ack}, 32'd0);

    // Fresh reset so the perf counters start from zero for the starvation case.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Starvation: continuous CPU reads, debug write forced on the 5th cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 32'hA5A5_A5A5;
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("starve_c%0d_stall", c), {31'b0, cpu_stall}, 32'd0);
      check($sformatf("starve_c%0d_addr", c), {24'b0, mem_addr}, 32'h10);
      next_cycle();
    end
    settle();
    check("starve_c5_stall", {31'b0, cpu_stall}, 32'd1);
    check("starve_c5_we", {31'b0, mem_we}, 32'd1);
    check("starve_c5_addr", {24'b0, mem_addr}, 32'h40);
    check("starve_c5_ack", {31'b0, dbg_ack}, 32'd0);
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
    settle();
    check("starve_c6_ack", {31'b0, dbg_ack}, 32'd1);
    check("starve_c6_stall", {31'b0, cpu_stall}, 32'd0);
    check("starve_c6_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("starve_mem40", mem[8'h40], 32'hA5A5_A5A5);
`ifdef ARB_PERF_CNT_EN
    check("starve_perf_stall", perf_stall_cnt, 32'd1);
    check("starve_perf_dbg", perf_dbg_cnt, 32'd1);
`else
    check("starve_perf_stall_off", perf_stall_cnt, 32'd0);
    check("starve_perf_dbg_off", perf_dbg_cnt, 32'd0);
`endif

    // Back-to-back debug reads with dbg_req held through the ack.
    next_cycle();
    cpu_req = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    settle();
    check("b2b_g0_addr", {24'b0, mem_addr}, 32'h20);
    next_cycle();
    settle();
    check("b2b_g1_ack", {31'b0, dbg_ack}, 32'd1);
    check("b2b_g1_no_access", {24'b0, mem_addr}, 32'h10);
    next_cycle();
    settle();
    check("b2b_g2_ack", {31'b0, dbg_ack}, 32'd0);
    check("b2b_g2_addr", {24'b0, mem_addr}, 32'h20);
    next_cycle();
    dbg_req = 1'b0;
    settle();
    check("b2b_g3_ack", {31'b0, dbg_ack}, 32'd1);
    check("b2b_g3_rdata", dbg_rdata, 32'h0000_1234);

    // Reset in the grant cycle of a debug write to 0x50 aborts it.
    next_cycle();
    rst = 1'b1; cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 32'hBAD0_BAD0;
    settle();
    check("rst_grant_we", {31'b0, mem_we}, 32'd0);
    next_cycle();
    rst = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    settle();
    check("rst_grant_no_ack", {31'b0, dbg_ack}, 32'd0);
    check("rst_grant_mem50", mem[8'h50], 32'h5555_0050);
    // Still IDLE: a new debug read is granted immediately.
    next_cycle();
    dbg_req = 1'b1; dbg_addr = 8'h50;
    settle();
    check("rst_grant_idle_addr", {24'b0, mem_addr}, 32'h50);
    next_cycle();
    dbg_req = 1'b0;
    settle();
    check("rst_grant_idle_ack", {31'b0, dbg_ack}, 32'd1);
    check("rst_grant_idle_rdata", dbg_rdata, 32'h5555_0050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates the single data memory between the CPU pipeline's MEM stage and an external debug/loader port. CPU accesses pass through combinationally with priority. Debug accesses use a req/ack handshake and are granted in CPU-idle cycles. A starvation counter forces a one-cycle debug grant, during which `cpu_stall` is raised. The block sits between `ExMemReg`/MEM-stage control and `data_mem`; `cpu_stall` feeds the hazard logic to freeze PC, IF/ID, ID/EX and EX/MEM.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all ports.
- `DATA_W`, 32, data width of all ports.
- `STARVE_LIMIT`, 4, denied debug cycles before a forced debug grant; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_req`  in  1  MEM stage needs memory this cycle (MemRead | MemWrite).
- `cpu_we`  in  1  CPU write enable (MemWrite).
- `cpu_addr`  in  ADDR_W  CPU address (EX/MEM ALU result).
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_rdata`  out  DATA_W  `mem_rdata` passthrough.
- `cpu_stall`  out  1  CPU access not serviced this cycle; pipeline must hold.
- `dbg_req`  in  1  debug access request; held until `dbg_ack`.
- `dbg_we`  in  1  debug write enable.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  DATA_W  registered read data; valid while `dbg_ack`=1.
- `mem_addr`  out  ADDR_W  to `data_mem` `addr_in`.
- `mem_wdata`  out  DATA_W  to `data_mem` `data_in`.
- `mem_we`  out  1  to `data_mem` `wr_en`.
- `mem_rdata`  in  DATA_W  from `data_mem` `data_out` (combinational read).
- `perf_stall_cnt`  out  32  count of CPU stall cycles.
- `perf_dbg_cnt`  out  32  count of debug grants.

## Operation
- **States:**
  - IDLE: debug requests are eligible.
  - DONE: the single cycle after a debug grant; `dbg_ack`=1 and `dbg_req` is ignored.
- **Debug grant** (`grant_dbg`, combinational):
  - Condition: state==IDLE & dbg_req & (~cpu_req | wait_cnt==STARVE_LIMIT).
  - Effect: mem_* driven from dbg_*.
  - Otherwise: mem_* driven from cpu_*, with mem_we = cpu_we & cpu_req.
- **Stall:** `cpu_stall` = grant_dbg & cpu_req. It is never asserted outside a debug grant.
- **Transitions:**
  - IDLE→DONE on grant_dbg.
  - DONE→IDLE unconditionally.
- **Data capture:** on a grant edge, `dbg_rdata` <= mem_rdata (captured for writes too). A debug write commits on that same edge.
- **`wait_cnt` (8-bit):**
  - Increments in IDLE when dbg_req & cpu_req & ~grant_dbg.
  - Clears on grant_dbg, or when dbg_req=0 in IDLE.
  - Holds in DONE.
- **Requester obligations:** debug must hold `dbg_addr/we/wdata` stable from `dbg_req` rise through `dbg_ack`. A `dbg_req` still high in the ack cycle is treated as a new request from the next cycle.
- **Reset:**
  - `rst`=1 forces `mem_we`=0 combinationally, so no write commits during reset.
  - The reset edge sets state=IDLE, wait_cnt=0, `dbg_ack`=0, `dbg_rdata`=0 and both perf counters=0.
  - Reset during a grant cycle aborts the access; no ack is issued.
- **Reset values of outputs:**
  - `dbg_ack`=0, `dbg_rdata`=0, perf counters=0.
  - `cpu_stall`=0 (grant_dbg is forced to 0 while `rst`=1).
  - `mem_*`, `cpu_rdata`: combinational CPU passthrough; `mem_we`=0 while `rst`=1.

## Timing
- CPU path: zero latency; address, data and we reach `data_mem` in the same cycle, and the write commits at the cycle-end edge.
- Debug latency: request granted in cycle G; `dbg_ack` and `dbg_rdata` valid in G+1.
- Maximum debug throughput: one access per 2 cycles.
- Worst-case debug wait under continuous `cpu_req`: STARVE_LIMIT cycles plus the grant cycle.
- Maximum CPU stall: 1 consecutive cycle per forced grant. In DONE the CPU always wins, so stall cycles are never back-to-back.

## Configuration
- `ARB_PERF_CNT_EN` defined:
  - `perf_stall_cnt` increments on every cycle with `cpu_stall`=1.
  - `perf_dbg_cnt` increments on every grant_dbg.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are generated.

## Test plan
- **Reset:** rst=1 with cpu_req=1, cpu_we=1 → mem_we=0, cpu_stall=0. After release → dbg_ack=0, dbg_rdata=0, perf counters=0.
- **CPU passthrough:** cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF; next cycle read of 0x10 → cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- **Idle debug read:** memory[0x20]=0x1234, cpu_req=0, dbg_req=1, dbg_addr=0x20 at cycle G → dbg_ack=1 and dbg_rdata=0x1234 at G+1, no stall.
- **Starvation:** STARVE_LIMIT=4, cpu_req=1 continuously, dbg_req=1 with a write of 0xA5A5A5A5 to 0x40:
  - Forced grant on the 5th cycle, with cpu_stall=1 for exactly that cycle.
  - dbg_ack on the 6th cycle.
  - memory[0x40]=0xA5A5A5A5.
  - With `ARB_PERF_CNT_EN`: perf_stall_cnt=1 and perf_dbg_cnt=1.
- **Back-to-back debug:** dbg_req held high through the ack cycle → second grant at G+2, second ack at G+3, no access issued in G+1.
- **Reset mid-grant:** rst=1 in grant cycle of a debug write to 0x50 → memory[0x50] unchanged, no dbg_ack, state IDLE.
